// File: rtl/rv32_writeback.sv
// rv32_writeback: write-back stage of the single-cycle RV32 core.
// Accepts one retired result per execute handshake. Non-load results go
// straight to the register-file write port one cycle later. Loads issue a
// single word read, wait in LOAD_WAIT for the response (bounded by a
// timeout), then extract and extend the addressed byte/half/word.
// Misaligned loads and memory timeouts are reported as one-cycle pulses,
// and every retired instruction bumps a free-running 32-bit counter.
//
// Handshake: execute -> writeback is strict valid/ready. A transfer happens
// on a rising edge where ex_valid_i & ex_ready_o are both high. ex_ready_o is
// decoded from the state alone and never depends on ex_valid_i, and the
// payload (ex_*_i) only has to be stable in cycles where ex_valid_i is high.
// The memory side has no backpressure: mem_req_o is a one-cycle strobe and
// mem_rvalid_i is only honoured while a load is outstanding (LOAD_WAIT).
module rv32_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // execute -> writeback
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  ex_rd_id_i,
  input  logic        ex_rd_write_en_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [7:0]  ex_load_store_info_i,
  // data memory read port
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  // register-file write port
  output logic        wb_rd_write_en_o,
  output logic [4:0]  wb_rd_id_o,
  output logic [31:0] wb_rd_write_data_o,
  // status
  output logic        wb_misalign_o,
  output logic        wb_timeout_o,
  output logic [31:0] wb_retire_cnt_o,
  // debug view of the FSM state (0 = IDLE, 1 = LOAD_WAIT)
  output logic [0:0]  dbg_state_o
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

  // Load kind encoding, captured while the read is outstanding
  localparam logic [2:0] K_LB  = 3'd0;
  localparam logic [2:0] K_LH  = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_LBU = 3'd3;
  localparam logic [2:0] K_LHU = 3'd4;

  // Counter start value; TIMEOUT_CYCLES is limited to 1..255
  localparam logic [7:0] TMO_INIT = 8'(TIMEOUT_CYCLES);

  logic [0:0]  state;
  logic [7:0]  tmo_cnt;

  // Load context held across LOAD_WAIT
  logic [4:0]  cap_rd_id;
  logic        cap_rd_en;
  logic [2:0]  cap_kind;
  logic [1:0]  cap_off;

  // Decode of the incoming execute result
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_kind;
  logic [1:0]  in_off;
  logic        in_misalign;
  logic        xfer;

  // Extracted load data
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_ready_o  = (state == ST_IDLE);
  assign dbg_state_o = state;
  assign xfer        = ex_valid_i & ex_ready_o;
  assign in_off      = ex_alu_result_i[1:0];

  // Classify the incoming instruction: load kind by priority, store, misalignment
  always_comb begin
    in_is_load  = |ex_load_store_info_i[7:3];
    in_is_store = |ex_load_store_info_i[2:0];
    in_kind     = K_LW;
    if (ex_load_store_info_i[7])      in_kind = K_LB;
    else if (ex_load_store_info_i[6]) in_kind = K_LH;
    else if (ex_load_store_info_i[5]) in_kind = K_LW;
    else if (ex_load_store_info_i[4]) in_kind = K_LBU;
    else if (ex_load_store_info_i[3]) in_kind = K_LHU;

    in_misalign = 1'b0;
    if (in_is_load) begin
      case (in_kind)
        K_LH, K_LHU: in_misalign = in_off[0];
        K_LW:        in_misalign = (in_off != 2'b00);
        default:     in_misalign = 1'b0;
      endcase
    end
  end

  // Select and extend the addressed byte/half of the returned word
  always_comb begin
    ld_byte = 8'(mem_rdata_i >> {cap_off, 3'b000});
    ld_half = cap_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (cap_kind)
      K_LB:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      K_LBU:   ld_data = {24'h000000, ld_byte};
      K_LH:    ld_data = {{16{ld_half[15]}}, ld_half};
      K_LHU:   ld_data = {16'h0000, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // FSM, load context, timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      tmo_cnt            <= 8'd0;
      cap_rd_id          <= 5'd0;
      cap_rd_en          <= 1'b0;
      cap_kind           <= K_LW;
      cap_off            <= 2'b00;
      mem_req_o          <= 1'b0;
      mem_addr_o         <= 32'd0;
      wb_rd_write_en_o   <= 1'b0;
      wb_rd_id_o         <= 5'd0;
      wb_rd_write_data_o <= 32'd0;
      wb_misalign_o      <= 1'b0;
      wb_timeout_o       <= 1'b0;
      wb_retire_cnt_o    <= 32'd0;
    end else begin
      // Strobes and pulses default low; each lasts exactly one cycle
      mem_req_o        <= 1'b0;
      wb_rd_write_en_o <= 1'b0;
      wb_misalign_o    <= 1'b0;
      wb_timeout_o     <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Late memory responses arriving here are deliberately ignored
          if (xfer) begin
            if (in_is_load) begin
              if (in_misalign) begin
                // Dropped: no request, no write, no retire
                wb_misalign_o <= 1'b1;
              end else begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= {ex_alu_result_i[31:2], 2'b00};
                cap_rd_id  <= ex_rd_id_i;
                cap_rd_en  <= ex_rd_write_en_i;
                cap_kind   <= in_kind;
                cap_off    <= in_off;
                tmo_cnt    <= TMO_INIT;
                state      <= ST_LOAD_WAIT;
              end
            end else begin
              // ALU result or store; stores never write rd, x0 is never written
              wb_rd_write_en_o   <= ex_rd_write_en_i & (ex_rd_id_i != 5'd0) & ~in_is_store;
              wb_rd_id_o         <= ex_rd_id_i;
              wb_rd_write_data_o <= ex_alu_result_i;
              wb_retire_cnt_o    <= wb_retire_cnt_o + 32'd1;
            end
          end
        end

        ST_LOAD_WAIT: begin
          // A response on the last allowed cycle beats the timeout
          if (mem_rvalid_i) begin
            wb_rd_write_en_o   <= cap_rd_en & (cap_rd_id != 5'd0);
            wb_rd_id_o         <= cap_rd_id;
            wb_rd_write_data_o <= ld_data;
            wb_retire_cnt_o    <= wb_retire_cnt_o + 32'd1;
            state              <= ST_IDLE;
          end else if (tmo_cnt == 8'd0) begin
            wb_timeout_o <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback: table-driven vectors for single transfers, plus
// hand-written sequences for timeout, response-on-last-cycle, stray
// responses, back-to-back retires and reset during an outstanding load.
// Expected register writes go into exp_q when stimulus is driven and are
// popped by a monitor whenever the write strobe is seen.
module tb_rv32_writeback;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_id_i;
  logic        ex_rd_write_en_i;
  logic [31:0] ex_alu_result_i;
  logic [7:0]  ex_load_store_info_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_rd_write_en_o;
  logic [4:0]  wb_rd_id_o;
  logic [31:0] wb_rd_write_data_o;
  logic        wb_misalign_o;
  logic        wb_timeout_o;
  logic [31:0] wb_retire_cnt_o;
  logic [0:0]  dbg_state_o;

  rv32_writeback #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_valid_i           (ex_valid_i),
    .ex_ready_o           (ex_ready_o),
    .ex_rd_id_i           (ex_rd_id_i),
    .ex_rd_write_en_i     (ex_rd_write_en_i),
    .ex_alu_result_i      (ex_alu_result_i),
    .ex_load_store_info_i (ex_load_store_info_i),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_rvalid_i         (mem_rvalid_i),
    .mem_rdata_i          (mem_rdata_i),
    .wb_rd_write_en_o     (wb_rd_write_en_o),
    .wb_rd_id_o           (wb_rd_id_o),
    .wb_rd_write_data_o   (wb_rd_write_data_o),
    .wb_misalign_o        (wb_misalign_o),
    .wb_timeout_o         (wb_timeout_o),
    .wb_retire_cnt_o      (wb_retire_cnt_o),
    .dbg_state_o          (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];        // {rd_id, write_data}
  logic [31:0] exp_retire = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every register-file write must match the oldest expected write
  always @(negedge clk) begin
    logic [36:0] got;
    logic [36:0] want;
    if (!rst && wb_rd_write_en_o) begin
      got = {wb_rd_id_o, wb_rd_write_data_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write actual=x%0d:%h required=no_write", wb_rd_id_o, wb_rd_write_data_o);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL sb_write actual=x%0d:%h required=x%0d:%h", got[36:32], got[31:0], want[36:32], want[31:0]);
        end
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        en;
    logic [7:0]  info;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] rd, input logic en, input logic [7:0] info,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_data, input logic exp_mis);
    vec_t v;
    v.rd = rd; v.en = en; v.info = info; v.addr = addr; v.rdata = rdata;
    v.exp_we = exp_we; v.exp_data = exp_data; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the transfer edge
  task automatic drive_xfer(input logic [4:0] rd, input logic en, input logic [7:0] info,
                            input logic [31:0] alu);
    ex_valid_i           = 1'b1;
    ex_rd_id_i           = rd;
    ex_rd_write_en_i     = en;
    ex_load_store_info_i = info;
    ex_alu_result_i      = alu;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int delay);
    check($sformatf("v%0d_ready_before", idx), ex_ready_o, 1);
    if (v.exp_we) exp_q.push_back({v.rd, v.exp_data});
    drive_xfer(v.rd, v.en, v.info, v.addr);
    if (|v.info[7:3]) begin
      if (v.exp_mis) begin
        check($sformatf("v%0d_misalign", idx), wb_misalign_o, 1);
        check($sformatf("v%0d_mis_no_req", idx), mem_req_o, 0);
        check($sformatf("v%0d_mis_no_we", idx), wb_rd_write_en_o, 0);
        check($sformatf("v%0d_mis_ready", idx), ex_ready_o, 1);
      end else begin
        check($sformatf("v%0d_req", idx), mem_req_o, 1);
        check($sformatf("v%0d_addr", idx), mem_addr_o, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d_busy", idx), ex_ready_o, 0);
        repeat (delay) begin @(posedge clk); #1; end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        exp_retire++;
        check($sformatf("v%0d_we", idx), wb_rd_write_en_o, v.exp_we);
        check($sformatf("v%0d_ready_after", idx), ex_ready_o, 1);
      end
    end else begin
      exp_retire++;
      check($sformatf("v%0d_we", idx), wb_rd_write_en_o, v.exp_we);
    end
    check($sformatf("v%0d_retire", idx), wb_retire_cnt_o, exp_retire);
  endtask

  // ---------------- test ----------------
  initial begin
    ex_valid_i = 1'b0; ex_rd_id_i = '0; ex_rd_write_en_i = 1'b0;
    ex_alu_result_i = '0; ex_load_store_info_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    //       rd  en info   addr/alu      rdata         we exp_data      mis
    add_vec(5,  1, 8'h00, 32'h12345678, 32'h0,        1, 32'h12345678, 0); // ALU write x5
    add_vec(0,  1, 8'h00, 32'h0000DEAD, 32'h0,        0, 32'h0,        0); // rd=0, no write
    add_vec(7,  1, 8'h80, 32'h00000103, 32'h80ABCD12, 1, 32'hFFFFFF80, 0); // lb byte3
    add_vec(7,  1, 8'h10, 32'h00000103, 32'h80ABCD12, 1, 32'h00000080, 0); // lbu byte3
    add_vec(8,  1, 8'h08, 32'h00000102, 32'h80ABCD12, 1, 32'h000080AB, 0); // lhu upper
    add_vec(9,  1, 8'h40, 32'h00000102, 32'h80ABCD12, 1, 32'hFFFF80AB, 0); // lh upper
    add_vec(10, 1, 8'h40, 32'h00000100, 32'h80ABCD12, 1, 32'hFFFFCD12, 0); // lh lower
    add_vec(10, 1, 8'h08, 32'h00000100, 32'h80ABCD12, 1, 32'h0000CD12, 0); // lhu lower
    add_vec(11, 1, 8'h80, 32'h00000101, 32'h80ABCD12, 1, 32'hFFFFFFCD, 0); // lb byte1
    add_vec(11, 1, 8'h10, 32'h00000102, 32'h80ABCD12, 1, 32'h000000AB, 0); // lbu byte2
    add_vec(13, 1, 8'h80, 32'h00000100, 32'h0000007F, 1, 32'h0000007F, 0); // lb positive
    add_vec(12, 1, 8'h20, 32'h00000200, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0); // lw
    add_vec(12, 1, 8'h20, 32'h00000101, 32'h0,        0, 32'h0,        1); // lw misaligned
    add_vec(14, 1, 8'h40, 32'h00000103, 32'h0,        0, 32'h0,        1); // lh misaligned
    add_vec(14, 1, 8'h08, 32'h00000101, 32'h0,        0, 32'h0,        1); // lhu misaligned
    add_vec(3,  1, 8'h01, 32'h00000040, 32'h0,        0, 32'h0,        0); // sw, no write
    add_vec(6,  0, 8'h20, 32'h00000010, 32'h00000005, 0, 32'h0,        0); // lw rd-enable off
    add_vec(0,  1, 8'h20, 32'h00000010, 32'h00000005, 0, 32'h0,        0); // lw to x0
    add_vec(15, 1, 8'hA0, 32'h00000101, 32'h80ABCD12, 1, 32'hFFFFFFCD, 0); // lb beats lw
    add_vec(16, 1, 8'h60, 32'h00000102, 32'h80ABCD12, 1, 32'hFFFF80AB, 0); // lh beats lw

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", ex_ready_o, 1);
    check("rst_state", dbg_state_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_we", wb_rd_write_en_o, 0);
    check("rst_rd", wb_rd_id_o, 0);
    check("rst_data", wb_rd_write_data_o, 0);
    check("rst_mis", wb_misalign_o, 0);
    check("rst_tmo", wb_timeout_o, 0);
    check("rst_retire", wb_retire_cnt_o, 0);

    // Table-driven single transfers
    foreach (vecs[i]) run_vec(i, vecs[i], i % 4);

    // Store then back-to-back ALU results: writes on consecutive cycles
    check("b2b_ready", ex_ready_o, 1);
    ex_valid_i = 1'b1; ex_rd_id_i = 5'd3; ex_rd_write_en_i = 1'b1;
    ex_load_store_info_i = 8'h01; ex_alu_result_i = 32'h00000300;
    @(posedge clk); #1;
    check("b2b_sw_no_we", wb_rd_write_en_o, 0);
    ex_rd_id_i = 5'd1; ex_load_store_info_i = 8'h00; ex_alu_result_i = 32'h00000011;
    exp_q.push_back({5'd1, 32'h00000011});
    @(posedge clk); #1;
    check("b2b_we1", wb_rd_write_en_o, 1);
    ex_rd_id_i = 5'd2; ex_alu_result_i = 32'h00000022;
    exp_q.push_back({5'd2, 32'h00000022});
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    check("b2b_we2", wb_rd_write_en_o, 1);
    exp_retire += 3;
    check("b2b_retire", wb_retire_cnt_o, exp_retire);

    // Timeout: pulse exactly TMO+2 cycles after the transfer
    drive_xfer(5'd4, 1'b1, 8'h20, 32'h00000040);
    for (int k = 1; k <= TMO + 2; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check($sformatf("tmo_pulse_c%0d", k), wb_timeout_o, (k == TMO + 2) ? 1 : 0);
    end
    check("tmo_ready", ex_ready_o, 1);
    check("tmo_no_we", wb_rd_write_en_o, 0);
    check("tmo_retire", wb_retire_cnt_o, exp_retire);
    // Stray response in IDLE
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    check("stray_no_we", wb_rd_write_en_o, 0);
    check("stray_retire", wb_retire_cnt_o, exp_retire);
    check("stray_tmo", wb_timeout_o, 0);

    // Response on the final timeout cycle wins
    drive_xfer(5'd20, 1'b1, 8'h20, 32'h00000080);
    repeat (TMO) begin @(posedge clk); #1; end
    check("last_busy", ex_ready_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADBEEF;
    exp_q.push_back({5'd20, 32'h0BADBEEF});
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    exp_retire++;
    check("last_we", wb_rd_write_en_o, 1);
    check("last_no_tmo", wb_timeout_o, 0);
    check("last_retire", wb_retire_cnt_o, exp_retire);
    @(posedge clk); #1;
    check("last_no_tmo_after", wb_timeout_o, 0);

    // Reset while a load is outstanding: dropped, outputs back to reset values
    drive_xfer(5'd21, 1'b1, 8'h20, 32'h000000C0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12121212;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    exp_retire = 32'd0;
    check("rlw_ready", ex_ready_o, 1);
    check("rlw_req", mem_req_o, 0);
    check("rlw_addr", mem_addr_o, 0);
    check("rlw_we", wb_rd_write_en_o, 0);
    check("rlw_rd", wb_rd_id_o, 0);
    check("rlw_data", wb_rd_write_data_o, 0);
    check("rlw_mis", wb_misalign_o, 0);
    check("rlw_tmo", wb_timeout_o, 0);
    check("rlw_retire", wb_retire_cnt_o, exp_retire);

    repeat (2) @(posedge clk);
    #1 check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
